// File: rtl/gp_cmd_dispatcher.sv
// gp_cmd_dispatcher
// Decodes 32-bit graphics command words from the command FIFO and drives
// the frame filler (FF) and line engine (LE) with single-cycle strobes.
// Supports FILL, LINE, POLYLINE, FRAME and STOP, plus restart via gp_start.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   gp_start          start/restart pulse; gp_frame is the default frame base
//   cmd_word/valid    command stream in; cmd_ready is the accept handshake
//   cmd_flush         pulse telling the FIFO to drop its contents on restart
//   gp_interrupt      pulse when STOP executes; busy is high outside IDLE
//   ff_*              frame filler request (colour, frame, valid pulse)
//   le_*              line engine colour/point strobes, trigger and frame
//
// Optional build macro GP_CMD_ERR_EN: adds err_flag (sticky) and
// err_opcode; an unknown opcode then interrupts and returns to IDLE.
// Without it, unknown opcodes are consumed and skipped.
module gp_cmd_dispatcher #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 24,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gp_start,
  input  logic [31:0]          gp_frame,
  input  logic [31:0]          cmd_word,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 cmd_flush,
  output logic                 gp_interrupt,
  output logic                 busy,
  input  logic                 ff_ready,
  output logic                 ff_valid,
  output logic [COLOR_W-1:0]   ff_color,
  output logic [31:0]          ff_frame,
  input  logic                 le_ready,
  output logic [COLOR_W-1:0]   le_color,
  output logic                 le_color_valid,
  output logic [2*COORD_W-1:0] le_point,
  output logic                 le_point0_valid,
  output logic                 le_point1_valid,
  output logic                 le_trigger,
  output logic [31:0]          le_frame
`ifdef GP_CMD_ERR_EN
  ,
  output logic                 err_flag,
  output logic [7:0]           err_opcode
`endif
);

  localparam logic [7:0] OP_STOP  = 8'h00;
  localparam logic [7:0] OP_FILL  = 8'h01;
  localparam logic [7:0] OP_LINE  = 8'h02;
  localparam logic [7:0] OP_PLINE = 8'h03;
  localparam logic [7:0] OP_FRAME = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_L_P0, S_L_P1, S_PL_CNT,
    S_PL_FIRST, S_PL_SEG, S_PL_P1, S_FR_W
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          frame_q, frame_d;
  logic [COLOR_W-1:0]   ff_color_q, ff_color_d, le_color_q, le_color_d;
  logic [2*COORD_W-1:0] point_q, point_d, prev_q, prev_d, cur_q, cur_d;
  logic [CNT_W-1:0]     seg_cnt_q, seg_cnt_d;
  logic ff_valid_q, ff_valid_d, le_cv_q, le_cv_d, le_p0_q, le_p0_d;
  logic le_p1_q, le_p1_d, flush_q, flush_d, irq_q, irq_d;
  logic ready_q, ready_d, busy_q, busy_d;
`ifdef GP_CMD_ERR_EN
  logic                 err_flag_q, err_flag_d;
  logic [7:0]           err_op_q, err_op_d;
`endif

  logic [7:0]           opcode_s;
  logic [2*COORD_W-1:0] word_pt_s;
  logic                 accept_s, strobe_now_s, strobe_next_s, needs_word_s;

  assign opcode_s  = cmd_word[31:24];
  assign word_pt_s = {cmd_word[16+COORD_W-1:16], cmd_word[COORD_W-1:0]};
  // A word offered alongside gp_start is dropped; the FIFO is flushed next cycle.
  assign accept_s     = cmd_valid & ready_q & ~gp_start;
  assign strobe_now_s = ff_valid_q | le_cv_q | le_p0_q | le_p1_q;

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    ff_color_d = ff_color_q;
    le_color_d = le_color_q;
    point_d    = point_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    seg_cnt_d  = seg_cnt_q;
    ff_valid_d = 1'b0;
    le_cv_d    = 1'b0;
    le_p0_d    = 1'b0;
    le_p1_d    = 1'b0;
    flush_d    = 1'b0;
    irq_d      = 1'b0;
`ifdef GP_CMD_ERR_EN
    err_flag_d = err_flag_q;
    err_op_d   = err_op_q;
`endif
    if (gp_start) begin
      // Restart wins over anything the current state would do this cycle.
      flush_d   = 1'b1;
      frame_d   = gp_frame;
      seg_cnt_d = {CNT_W{1'b0}};
      state_d   = S_DECODE;
`ifdef GP_CMD_ERR_EN
      err_flag_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_DECODE: begin
          if (accept_s) begin
            case (opcode_s)
              OP_STOP: begin
                irq_d   = 1'b1;
                state_d = S_IDLE;
              end
              OP_FILL: begin
                ff_color_d = cmd_word[COLOR_W-1:0];
                ff_valid_d = 1'b1;
              end
              OP_LINE: begin
                le_color_d = cmd_word[COLOR_W-1:0];
                le_cv_d    = 1'b1;
                state_d    = S_L_P0;
              end
              OP_PLINE: begin
                le_color_d = cmd_word[COLOR_W-1:0];
                le_cv_d    = 1'b1;
                state_d    = S_PL_CNT;
              end
              OP_FRAME: state_d = S_FR_W;
              default: begin
`ifdef GP_CMD_ERR_EN
                err_flag_d = 1'b1;
                err_op_d   = opcode_s;
                irq_d      = 1'b1;
                state_d    = S_IDLE;
`else
                state_d    = S_DECODE;
`endif
              end
            endcase
          end else begin
            state_d = S_DECODE;
          end
        end
        S_L_P0: begin
          if (accept_s) begin
            point_d = word_pt_s;
            le_p0_d = 1'b1;
            state_d = S_L_P1;
          end else begin
            state_d = S_L_P0;
          end
        end
        S_L_P1: begin
          if (accept_s) begin
            point_d = word_pt_s;
            le_p1_d = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_L_P1;
          end
        end
        S_PL_CNT: begin
          if (accept_s) begin
            seg_cnt_d = cmd_word[CNT_W-1:0];
            if (cmd_word[CNT_W-1:0] == {CNT_W{1'b0}}) begin
              state_d = S_DECODE;
            end else begin
              state_d = S_PL_FIRST;
            end
          end else begin
            state_d = S_PL_CNT;
          end
        end
        S_PL_FIRST: begin
          if (accept_s) begin
            prev_d  = word_pt_s;
            state_d = S_PL_SEG;
          end else begin
            state_d = S_PL_FIRST;
          end
        end
        S_PL_SEG: begin
          // Segment start point is the previous end point; new point waits in cur.
          if (accept_s) begin
            point_d = prev_q;
            le_p0_d = 1'b1;
            cur_d   = word_pt_s;
            state_d = S_PL_P1;
          end else begin
            state_d = S_PL_SEG;
          end
        end
        S_PL_P1: begin
          // Keep a gap after the point0 strobe and wait for the engine.
          if (le_ready && !strobe_now_s) begin
            point_d   = cur_q;
            le_p1_d   = 1'b1;
            prev_d    = cur_q;
            seg_cnt_d = seg_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            if (seg_cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state_d = S_DECODE;
            end else begin
              state_d = S_PL_SEG;
            end
          end else begin
            state_d = S_PL_P1;
          end
        end
        S_FR_W: begin
          if (accept_s) begin
            frame_d = cmd_word;
            state_d = S_DECODE;
          end else begin
            state_d = S_FR_W;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_IDLE, S_PL_P1: needs_word_s = 1'b0;
      default:         needs_word_s = 1'b1;
    endcase
    strobe_next_s = ff_valid_d | le_cv_d | le_p0_d | le_p1_d;
    // No acceptance in a strobe cycle or the cycle after, so strobes stay spaced.
    ready_d = needs_word_s & ff_ready & le_ready & ~strobe_next_s & ~strobe_now_s & ~gp_start;
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      frame_q    <= 32'h0000_0000;
      ff_color_q <= {COLOR_W{1'b0}};
      le_color_q <= {COLOR_W{1'b0}};
      point_q    <= {(2*COORD_W){1'b0}};
      prev_q     <= {(2*COORD_W){1'b0}};
      cur_q      <= {(2*COORD_W){1'b0}};
      seg_cnt_q  <= {CNT_W{1'b0}};
      ff_valid_q <= 1'b0;
      le_cv_q    <= 1'b0;
      le_p0_q    <= 1'b0;
      le_p1_q    <= 1'b0;
      flush_q    <= 1'b0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef GP_CMD_ERR_EN
      err_flag_q <= 1'b0;
      err_op_q   <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      ff_color_q <= ff_color_d;
      le_color_q <= le_color_d;
      point_q    <= point_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      seg_cnt_q  <= seg_cnt_d;
      ff_valid_q <= ff_valid_d;
      le_cv_q    <= le_cv_d;
      le_p0_q    <= le_p0_d;
      le_p1_q    <= le_p1_d;
      flush_q    <= flush_d;
      irq_q      <= irq_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef GP_CMD_ERR_EN
      err_flag_q <= err_flag_d;
      err_op_q   <= err_op_d;
`endif
    end
  end

  assign cmd_ready       = ready_q;
  assign cmd_flush       = flush_q;
  assign gp_interrupt    = irq_q;
  assign busy            = busy_q;
  assign ff_valid        = ff_valid_q;
  assign ff_color        = ff_color_q;
  assign ff_frame        = frame_q;
  assign le_color        = le_color_q;
  assign le_color_valid  = le_cv_q;
  assign le_point        = point_q;
  assign le_point0_valid = le_p0_q;
  assign le_point1_valid = le_p1_q;
  assign le_trigger      = le_p1_q;
  assign le_frame        = frame_q;
`ifdef GP_CMD_ERR_EN
  assign err_flag        = err_flag_q;
  assign err_opcode      = err_op_q;
`endif

endmodule

// File: tb/tb_gp_cmd_dispatcher.sv
// Scoreboard bench for gp_cmd_dispatcher: a command-grammar reference model
// turns each accepted word into expected engine events; a monitor pops and
// compares them whenever the DUT raises a strobe, flush or interrupt.
module tb_gp_cmd_dispatcher;
  localparam int COORD_W = 10;
  localparam int COLOR_W = 24;
  localparam int CNT_W   = 16;
  localparam int K_FF = 0, K_LC = 1, K_P0 = 2, K_P1 = 3, K_IRQ = 4, K_FL = 5;

  logic clk = 1'b0;
  logic rst_n, gp_start, cmd_valid, ff_ready, le_ready;
  logic [31:0] gp_frame, cmd_word;
  logic cmd_ready, cmd_flush, gp_interrupt, busy, ff_valid;
  logic le_color_valid, le_point0_valid, le_point1_valid, le_trigger;
  logic [COLOR_W-1:0] ff_color, le_color;
  logic [31:0] ff_frame, le_frame;
  logic [2*COORD_W-1:0] le_point;

  always #5 clk = ~clk;

  gp_cmd_dispatcher #(.COORD_W(COORD_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .gp_start(gp_start), .gp_frame(gp_frame),
    .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_flush(cmd_flush), .gp_interrupt(gp_interrupt), .busy(busy),
    .ff_ready(ff_ready), .ff_valid(ff_valid), .ff_color(ff_color), .ff_frame(ff_frame),
    .le_ready(le_ready), .le_color(le_color), .le_color_valid(le_color_valid),
    .le_point(le_point), .le_point0_valid(le_point0_valid),
    .le_point1_valid(le_point1_valid), .le_trigger(le_trigger), .le_frame(le_frame)
  );

  typedef struct { int kind; logic [31:0] data; logic [31:0] frame; } ev_t;
  ev_t         exp_q[$];
  logic [31:0] fifo[$];
  int checks = 0, errors = 0;
  int trig_seen = 0, irq_seen = 0, pt_seen = 0;
  bit mon_en = 1'b0, le_hold = 1'b0, rnd_restart = 1'b0, start_req = 1'b0;
  bit prev_strobe = 1'b0, strobe_now;
  logic [31:0] start_frame;

  // reference model state: pending command and its collected points
  int pend = 0;
  int nseg = -1;
  logic [31:0] m_frame = 32'h0;
  logic [2*COORD_W-1:0] pts[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_ev(int k, logic [31:0] d, logic [31:0] f);
    ev_t e;
    e.kind = k; e.data = d; e.frame = f;
    exp_q.push_back(e);
  endfunction

  function automatic logic [2*COORD_W-1:0] pt(logic [31:0] w);
    return {w[16+COORD_W-1:16], w[COORD_W-1:0]};
  endfunction

  // Command grammar: opcode word, then the argument words it calls for.
  function automatic void model_word(logic [31:0] w);
    int n;
    case (pend)
      0: case (w[31:24])
        8'h00: push_ev(K_IRQ, 32'h0, 32'h0);
        8'h01: push_ev(K_FF, 32'(w[COLOR_W-1:0]), m_frame);
        8'h02, 8'h03: begin
          push_ev(K_LC, 32'(w[COLOR_W-1:0]), m_frame);
          pend = int'(w[31:24]);
          pts.delete();
          nseg = -1;
        end
        8'h04: pend = 4;
        default: ;
      endcase
      2: begin
        pts.push_back(pt(w));
        if (pts.size() == 1) push_ev(K_P0, 32'(pts[0]), m_frame);
        else begin
          push_ev(K_P1, 32'(pts[1]), m_frame);
          pend = 0;
        end
      end
      3: begin
        if (nseg < 0) begin
          nseg = int'(w[CNT_W-1:0]);
          if (nseg == 0) pend = 0;
        end else begin
          pts.push_back(pt(w));
          n = pts.size();
          if (n >= 2) begin
            push_ev(K_P0, 32'(pts[n-2]), m_frame);
            push_ev(K_P1, 32'(pts[n-1]), m_frame);
          end
          if (n == nseg + 1) pend = 0;
        end
      end
      4: begin
        m_frame = w;
        pend = 0;
      end
      default: pend = 0;
    endcase
  endfunction

  function automatic void observe(int k, logic [31:0] d, logic [31:0] f);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected no event", k);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", k, e.kind);
    if (k == e.kind && k != K_IRQ) begin
      chk("event_data", d, e.data);
      chk("event_frame", f, e.frame);
    end
  endfunction

  // Monitor: sample one time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        int n;
        n = int'(ff_valid) + int'(le_color_valid) + int'(le_point0_valid) +
            int'(le_point1_valid) + int'(gp_interrupt) + int'(cmd_flush);
        if (n > 1) chk("one_event_per_cycle", n, 1);
        if (le_trigger || le_point1_valid) chk("trigger_with_p1", le_trigger, le_point1_valid);
        if (ff_valid) observe(K_FF, 32'(ff_color), ff_frame);
        else if (le_color_valid) observe(K_LC, 32'(le_color), le_frame);
        else if (le_point0_valid) begin observe(K_P0, 32'(le_point), le_frame); pt_seen++; end
        else if (le_point1_valid) begin observe(K_P1, 32'(le_point), le_frame); pt_seen++; trig_seen++; end
        else if (gp_interrupt) begin observe(K_IRQ, 32'h0, 32'h0); irq_seen++; end
        else if (cmd_flush) observe(K_FL, ff_frame, le_frame);
      end
    end
  end

  // One clock of stimulus, driven at the falling edge.
  task automatic cycle();
    bit bad;
    @(negedge clk);
    strobe_now = ff_valid | le_color_valid | le_point0_valid | le_point1_valid;
    if (strobe_now) chk("strobe_spacing", prev_strobe, 0);
    if (cmd_ready) chk("ready_after_strobe", prev_strobe, 0);
    prev_strobe = strobe_now;
    if (start_req) begin
      // Only a polyline end point still waiting on the engine may be cut off.
      bad = exp_q.size() > 1 || (exp_q.size() == 1 && exp_q[0].kind != K_P1);
      chk("restart_leftover", bad, 0);
      exp_q.delete(); fifo.delete();
      pend = 0; m_frame = start_frame;
      push_ev(K_FL, start_frame, start_frame);
      gp_start = 1'b1; gp_frame = start_frame;
      cmd_valid = 1'b1; cmd_word = 32'h0000_0000;   // STOP offered alongside restart
      start_req = 1'b0;
    end else begin
      gp_start = 1'b0; gp_frame = $urandom();
      cmd_valid = (fifo.size() > 0) && ($urandom_range(0, 4) != 0);
      cmd_word = cmd_valid ? fifo[0] : $urandom();
    end
    ff_ready = ($urandom_range(0, 3) != 0);
    le_ready = le_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (cmd_valid && cmd_ready && !gp_start) model_word(fifo.pop_front());
    if (rnd_restart && $urandom_range(0, 299) == 0) begin
      start_req = 1'b1; start_frame = $urandom();
    end
  endtask

  task automatic restart(input logic [31:0] f);
    start_req = 1'b1; start_frame = f;
    cycle();
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (fifo.size() == 0 && exp_q.size() == 0) break;
      cycle();
    end
    chk("drain_timeout", 32'(fifo.size() + exp_q.size()), 0);
    repeat (3) cycle();
  endtask

  initial begin
    int base, nc, ns, op, nw;
    logic [31:0] fa;
    logic [2*COORD_W-1:0] exp_pt;
    rst_n = 1'b0; gp_start = 1'b0; gp_frame = 32'h0; cmd_word = 32'h0;
    cmd_valid = 1'b0; ff_ready = 1'b1; le_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flush_irq", {cmd_flush, gp_interrupt}, 0);
    chk("rst_strobes", {ff_valid, le_color_valid, le_point0_valid, le_point1_valid, le_trigger}, 0);
    chk("rst_ff_frame", ff_frame, 0);
    chk("rst_le_point", le_point, 0);
    chk("rst_colors", {ff_color, le_color}, 0);
    @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;

    // FILL then STOP
    restart(32'h1040_0000);
    base = irq_seen;
    fifo.push_back(32'h01FF_0000); fifo.push_back(32'h0000_0000);
    drain(300);
    chk("t1_irq_count", irq_seen - base, 1);
    chk("t1_busy_after_stop", busy, 0);

    // LINE
    restart($urandom());
    fifo.push_back(32'h0200_FF00); fifo.push_back(32'h0005_0007); fifo.push_back(32'h0100_0020);
    drain(300);
    exp_pt = {10'd256, 10'd32};
    chk("t2_le_point", le_point, exp_pt);
    chk("t2_le_color", le_color, 32'h0000_FF00);

    // POLYLINE with three segments
    restart($urandom());
    base = trig_seen;
    fifo.push_back(32'h0312_3456); fifo.push_back(32'h0000_0003);
    repeat (4) fifo.push_back($urandom());
    fifo.push_back(32'h0000_0000);
    drain(500);
    chk("t3_trigger_count", trig_seen - base, 3);

    // POLYLINE with zero segments, then STOP
    restart($urandom());
    base = pt_seen; nw = irq_seen;
    fifo.push_back(32'h03AB_CDEF); fifo.push_back(32'hBEEF_0000); fifo.push_back(32'h0000_0000);
    drain(300);
    chk("t4_point_strobes", pt_seen - base, 0);
    chk("t4_irq_count", irq_seen - nw, 1);

    // FRAME override, then restart restores the default frame
    restart($urandom());
    fifo.push_back(32'h0400_0000); fifo.push_back(32'h1080_0000);
    fifo.push_back(32'h01AB_CDEF); fifo.push_back(32'h0000_0000);
    drain(300);
    chk("t5_ff_frame_override", ff_frame, 32'h1080_0000);
    fa = $urandom();
    restart(fa);
    drain(50);
    chk("t5_ff_frame_restored", ff_frame, fa);
    chk("t5_le_frame_restored", le_frame, fa);

    // Backpressure, then abort mid-polyline
    restart($urandom());
    base = trig_seen;
    fifo.push_back(32'h0312_3456); fifo.push_back(32'h0000_0003);
    repeat (4) fifo.push_back($urandom());
    for (int i = 0; i < 500 && trig_seen == base; i++) cycle();
    chk("t6_first_trigger", trig_seen > base, 1);
    le_hold = 1'b1;
    repeat (2) cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t6_ready_held_low", cmd_ready, 0);
    end
    base = trig_seen;
    restart($urandom());
    le_hold = 1'b0;
    repeat (20) cycle();
    chk("t6_no_trigger_after_abort", trig_seen, base);
    chk("t6_busy_in_decode", busy, 1);
    for (int i = 0; i < 50 && !cmd_ready; i++) cycle();
    chk("t6_ready_in_decode", cmd_ready, 1);

    // Randomised programs with occasional restarts
    rnd_restart = 1'b1;
    for (int p = 0; p < 40; p++) begin
      restart($urandom());
      nc = $urandom_range(3, 8);
      for (int c = 0; c < nc; c++) begin
        case ($urandom_range(0, 5))
          1: begin
            fifo.push_back({8'h02, 24'($urandom())});
            fifo.push_back($urandom()); fifo.push_back($urandom());
          end
          2: begin
            ns = $urandom_range(0, 4);
            fifo.push_back({8'h03, 24'($urandom())});
            fifo.push_back({16'($urandom()), 16'(ns)});
            if (ns > 0) for (int k = 0; k <= ns; k++) fifo.push_back($urandom());
          end
          3: begin
            fifo.push_back({8'h04, 24'($urandom())});
            fifo.push_back($urandom());
          end
          4: begin
            op = $urandom_range(5, 255);
            fifo.push_back({8'(op), 24'($urandom())});
          end
          default: fifo.push_back({8'h01, 24'($urandom())});
        endcase
      end
      fifo.push_back(32'h0000_0000);
      drain(3000);
    end
    rnd_restart = 1'b0;

    // Asynchronous reset in the middle of a LINE command
    restart($urandom());
    fifo.push_back(32'h0277_8899);
    drain(100);
    chk("t8_busy_mid_line", busy, 1);
    mon_en = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t8_reset_busy", busy, 0);
    chk("t8_reset_le_color", le_color, 0);
    chk("t8_reset_ff_frame", ff_frame, 0);
    chk("t8_reset_cmd_ready", cmd_ready, 0);
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gp_cmd_dispatcher.md
Name: gp_cmd_dispatcher

Overview:
Parametrised successor to the graphics command processor. Consumes a stream of 32-bit graphics command words from the command fetch FIFO, decodes them, and drives the frame filler and line engine through single-cycle valid pulses. Adds polyline, frame-override and abort/restart support, and parametrised coordinate and colour widths. Sits between the command FIFO/DRAM fetch path and the FF/LE engines.

Parameters:
COORD_W, 10, bits per X or Y coordinate; le_point is 2*COORD_W bits wide.
COLOR_W, 24, colour width, taken from cmd_word[COLOR_W-1:0]; COLOR_W must be 24 or less.
CNT_W, 16, polyline segment-count width, taken from cmd_word[CNT_W-1:0].

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
gp_start  in  1  one-cycle pulse: start or restart command processing
gp_frame  in  32  default frame base address
cmd_word  in  32  command word from the FIFO
cmd_valid  in  1  cmd_word is valid
cmd_ready  out  1  word accepted when cmd_valid and cmd_ready are both high
cmd_flush  out  1  one-cycle pulse: discard FIFO contents (on restart)
gp_interrupt  out  1  one-cycle pulse: STOP executed
busy  out  1  high in every state except IDLE
ff_ready  in  1  frame filler idle
ff_valid  out  1  fill request pulse
ff_color  out  COLOR_W  fill colour
ff_frame  out  32  active frame base
le_ready  in  1  line engine idle
le_color  out  COLOR_W  line colour
le_color_valid  out  1  colour strobe
le_point  out  2*COORD_W  point, packed {x,y}
le_point0_valid  out  1  start-point strobe
le_point1_valid  out  1  end-point strobe
le_trigger  out  1  start line draw
le_frame  out  32  active frame base

Behaviour:
- Reset: all strobes, cmd_ready, cmd_flush, gp_interrupt and busy are 0. Colour, point and frame registers are 0. State is IDLE.
- All outputs are registered. A strobe appears in the cycle after the enabling word is accepted.
- Opcode is cmd_word[31:24].
  - 0x00 STOP
  - 0x01 FILL
  - 0x02 LINE
  - 0x03 POLYLINE
  - 0x04 FRAME
- Point words: x = cmd_word[16+COORD_W-1:16], y = cmd_word[COORD_W-1:0].
- Engine gating: cmd_ready is high only when the current state needs a word, ff_ready=1 and le_ready=1, and no strobe was issued in the previous cycle. The engines therefore see at most one strobe per two cycles.
- States:
  - IDLE: wait for gp_start, then load frame_r=gp_frame and go to DECODE.
  - DECODE: accept one word, then branch:
    - STOP: pulse gp_interrupt, go to IDLE.
    - FILL: ff_color=word[COLOR_W-1:0], pulse ff_valid, stay in DECODE.
    - LINE: set le_color and pulse le_color_valid, go to L_P0.
    - POLYLINE: set colour and pulse le_color_valid, go to PL_CNT.
    - FRAME: go to FR_W.
    - Unknown opcode: discard (see optional feature), stay in DECODE.
  - L_P0: accept a point, pulse le_point0_valid, go to L_P1.
  - L_P1: accept a point, pulse le_point1_valid and le_trigger together, go to DECODE.
  - PL_CNT: accept a word and load seg_cnt=word[CNT_W-1:0].
    - seg_cnt=0: go to DECODE; no point words are consumed.
    - Otherwise go to PL_FIRST.
  - PL_FIRST: accept a point, store it as prev (no strobe), go to PL_SEG.
  - PL_SEG: accept a point, then:
    - Emit le_point0_valid with prev, wait for le_ready=1.
    - Emit le_point1_valid and le_trigger with the new point.
    - prev = new point, seg_cnt decrements.
    - At seg_cnt=0, go to DECODE.
    - A polyline of N segments consumes N+1 points and fires N triggers.
  - FR_W: accept a word, set frame_r=word, go to DECODE. ff_frame and le_frame follow frame_r.
- Restart: gp_start in any state, including mid-polyline:
  - pulse cmd_flush;
  - reload frame_r=gp_frame;
  - clear all strobes and seg_cnt;
  - go to DECODE next cycle.
  - Any word offered in the cycle gp_start is high is not accepted.
- gp_start and a STOP word in the same cycle: the restart wins and gp_interrupt is not pulsed.
- cmd_valid=0 in any word-waiting state: hold state; no timeout.
- Reset asserted mid-operation: return immediately to the reset values above. Engines must be reset alongside this block.

Optional Feature:
GP_CMD_ERR_EN.
- Defined: adds output err_flag (1 bit, sticky; cleared by gp_start or reset) and output err_opcode (8 bits, the last unknown opcode). On an unknown opcode, set err_flag and go to IDLE, pulsing gp_interrupt.
- Undefined: unknown opcodes are consumed and silently skipped. No extra ports.

Test Plan:
- FILL then STOP. gp_start, gp_frame=0x10400000, words 0x01FF0000, 0x00000000 -> one ff_valid with ff_color=0xFF0000 and ff_frame=0x10400000, then one gp_interrupt pulse and busy=0.
- LINE. Words 0x0200FF00, 0x00050007, 0x01000020 -> le_color=0x00FF00; le_point0_valid with {x=5,y=7}; le_point1_valid with le_trigger and {x=256,y=32}.
- POLYLINE, N=3. Header 0x03123456, count 0x00000003, then 4 points -> exactly 3 le_trigger pulses; each segment's point0 equals the previous point1.
- POLYLINE with count=0 followed by STOP -> no point strobes, gp_interrupt fires.
- FRAME 0x04000000, then 0x10800000, then FILL -> ff_frame=0x10800000. A following gp_start restores ff_frame to gp_frame.
- Backpressure and abort. Hold le_ready=0 during a POLYLINE -> cmd_ready stays 0. Then gp_start mid-segment -> cmd_flush pulses, no further triggers are issued, state is DECODE.
